// File: rtl/aux_boot_pkg.sv
// Shared types and helpers for the auxiliary UART boot loader.
// The RX state encoding and the divider arithmetic live here so that the receiver and the top agree on them.
package aux_boot_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLK_FREQUENCY = 50000000;
    localparam int DEF_BAUD_RATE     = 115200;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_div(input int div);
        return div / 2;
    endfunction

    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    localparam int DEF_DIV      = calc_div(DEF_CLK_FREQUENCY, DEF_BAUD_RATE);
    localparam int DEF_HALF_DIV = half_div(DEF_DIV);
    localparam int DEF_CNT_W    = cnt_width(DEF_DIV);

    // Byte-lane enable for a partial word holding 'lanes' bytes, starting at lane 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] lanes);
        case (lanes)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/aux_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer; o_state exposes the FSM for debug.
// AUX_UART_FRAME_ERR_EN enables the stop-bit check and the o_frame_err pulse.
module aux_uart_rx
    import aux_boot_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_start,
    output logic [1:0] o_state
`ifdef AUX_UART_FRAME_ERR_EN
    ,
    output logic       o_frame_err
`endif
);
    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(half_div(DIV));
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);

    // o_byte_valid is a one-cycle pulse with o_byte_data stable alongside it; there is no ready, the consumer must take it.
    rx_state_t        r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
`ifdef AUX_UART_FRAME_ERR_EN
    logic             r_frame_err;
`endif
    logic             w_start;
    logic             w_tick;

    assign w_start = (r_state == RX_IDLE) && r_sync_d && !r_sync2;
    assign w_tick  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_d     <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
`ifdef AUX_UART_FRAME_ERR_EN
            r_frame_err  <= 1'b0;
`endif
        end else begin
            r_sync1      <= rx;
            r_sync2      <= r_sync1;
            r_sync_d     <= r_sync2;
            r_byte_valid <= 1'b0;
`ifdef AUX_UART_FRAME_ERR_EN
            r_frame_err  <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    if (w_start) begin
                        r_state <= RX_START;
                        r_cnt   <= HALF;
                    end
                end
                RX_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_sync2) begin
                        r_state <= RX_IDLE;
                    end else begin
                        r_state <= RX_DATA;
                        r_cnt   <= FULL;
                        r_bit   <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= RX_IDLE;
`ifdef AUX_UART_FRAME_ERR_EN
                        if (r_sync2) r_byte_valid <= 1'b1;
                        else         r_frame_err  <= 1'b1;
`else
                        r_byte_valid <= 1'b1;
`endif
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_start      = w_start;
    assign o_state      = r_state;
`ifdef AUX_UART_FRAME_ERR_EN
    assign o_frame_err  = r_frame_err;
`endif

endmodule

// File: rtl/aux_uart_boot_loader.sv
// Boot loader top: packs UART bytes into 32-bit words, writes program memory, and holds the MCU in reset meanwhile.
// Optional macro AUX_UART_FRAME_ERR_EN: discard frames with a bad stop bit and add the sticky frame_err output.
module aux_uart_boot_loader
    import aux_boot_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 50000000,
    parameter int BAUD_RATE      = 115200,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              boot_active,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_ble,
    output logic [ADDR_W+1:0] byte_count
`ifdef AUX_UART_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);
    localparam int DIV  = calc_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_start;
    logic [1:0]        w_rx_state;
    logic              w_busy;
    logic              w_timeout;
    logic [1:0]        w_lane_eff;
    logic [31:0]       w_word;
`ifdef AUX_UART_FRAME_ERR_EN
    logic              w_frame_err;
`endif

    logic              r_boot;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_ble;
    logic [ADDR_W+1:0] r_count;
    logic [1:0]        r_lane;
    logic [TO_W-1:0]   r_tcnt;
    logic              r_final;

    aux_uart_rx #(.DIV(DIV)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte),
        .o_start      (w_start),
        .o_state      (w_rx_state)
`ifdef AUX_UART_FRAME_ERR_EN
        ,
        .o_frame_err  (w_frame_err)
`endif
    );

    assign w_busy    = (w_rx_state != RX_IDLE);
    // A start edge in the same cycle as the timeout keeps the session alive.
    assign w_timeout = r_boot && !w_busy && !w_start && !w_byte_valid && (r_tcnt == TO_LAST);
    assign w_lane_eff = r_boot ? r_lane : 2'd0;

    always_comb begin
        w_word = (w_lane_eff == 2'd0) ? 32'h0 : r_wdata;
        case (w_lane_eff)
            2'd0: w_word[7:0]   = w_byte;
            2'd1: w_word[15:8]  = w_byte;
            2'd2: w_word[23:16] = w_byte;
            2'd3: w_word[31:24] = w_byte;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (!r_boot || w_busy || w_start || w_byte_valid || w_timeout) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_boot  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_ble   <= 4'h0;
            r_count <= '0;
            r_lane  <= 2'd0;
            r_final <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_ble <= 4'h0;
            if (w_byte_valid) begin
                r_boot  <= 1'b1;
                r_wdata <= w_word;
                r_lane  <= w_lane_eff + 2'd1;
                r_count <= r_boot ? r_count + (ADDR_W+2)'(1) : (ADDR_W+2)'(1);
                if (!r_boot) begin
                    r_addr  <= '0;
                    r_final <= 1'b0;
                end
                if (w_lane_eff == 2'd3) begin
                    r_we  <= 1'b1;
                    r_ble <= 4'hF;
                end
            end else if (r_we) begin
                // The address advances only after the write cycle and never wraps past the last word.
                if (r_final || r_addr == LAST_ADDR) begin
                    r_boot  <= 1'b0;
                    r_final <= 1'b0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end else if (w_timeout) begin
                if (r_lane != 2'd0) begin
                    r_we    <= 1'b1;
                    r_ble   <= lane_mask(r_lane);
                    r_final <= 1'b1;
                end else begin
                    r_boot <= 1'b0;
                end
            end
        end
    end

`ifdef AUX_UART_FRAME_ERR_EN
    logic r_frame_err;
    logic r_err_idle;

    // Errors seen between sessions survive into the next session; older ones are dropped when it starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_err_idle  <= 1'b0;
        end else if (w_byte_valid && !r_boot) begin
            r_frame_err <= r_err_idle;
            r_err_idle  <= 1'b0;
        end else if (w_frame_err) begin
            r_frame_err <= 1'b1;
            if (!r_boot) r_err_idle <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`endif

    assign boot_active = r_boot;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_ble     = r_ble;
    assign byte_count  = r_count;

endmodule
